// File: rtl/dpll_test_tx_if.sv
// Payload byte handshake between a byte source and the DPLL test transmitter.
interface dpll_test_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/dpll_test_tx.sv
// Serial NRZ test transmitter feeding the DPLL clock-recovery path.
// Sends an alternating preamble followed by buffered payload bytes (MSB first),
// substituting fill byte 8'h55 when no payload is waiting. Per-bit phase steps
// stretch or shrink a single bit to exercise DPLL pull-in and tracking.
// Optional feature macro: PRBS_GEN_EN adds input prbs_mode, which replaces the
// payload with a PRBS-7 sequence (x^7+x^6+1, seed 7'h7F).
module dpll_test_tx #(
  parameter int CLK_PER_BIT = 200000,
  parameter int STEP_UNIT   = 100,
  parameter int PRE_BITS    = 8
) (
  input  logic              CLK_100MHz,
  input  logic              reset,
  input  logic              enable,
  dpll_test_tx_if.slave     tx,
  input  logic signed [7:0] phase_step,
  input  logic              step_stb,
`ifdef PRBS_GEN_EN
  input  logic              prbs_mode,
`endif
  output logic              signal,
  output logic              bit_tick,
  output logic              underrun,
  output logic              busy
);

  localparam int         CNT_W = $clog2(CLK_PER_BIT + 128 * STEP_UNIT + 1);
  localparam int         BC_W  = ($clog2(PRE_BITS + 1) < 3) ? 3 : $clog2(PRE_BITS + 1);
  localparam logic [7:0] FILL  = 8'h55;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_PAY} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic              hold_vld_q, hold_vld_d;
  logic              pend_q, pend_d;
  logic              sig_q, sig_d;
  logic              tick_q, tick_d;
  logic              und_q, und_d;
  logic [7:0]        hold_q, hold_d;
  logic [7:0]        shift_q, shift_d;
  logic signed [7:0] step_q, step_d;
  logic              prbs_on;
  logic              bit_start;
  logic              accept;

`ifdef PRBS_GEN_EN
  logic [6:0]        lfsr_q, lfsr_d;
  assign prbs_on = prbs_mode;
`else
  assign prbs_on = 1'b0;
`endif

  // Bit length minus one for the timer reload; a pending step adjusts the
  // nominal length and the result saturates at a floor of 8 cycles.
  function automatic logic [CNT_W-1:0] bit_len_m1(input logic pend,
                                                  input logic signed [7:0] step);
    logic signed [31:0] len;
    len = 32'(CLK_PER_BIT);
    if (pend) len = len + 32'(step) * 32'(STEP_UNIT);
    if (len < 32'sd8) len = 32'sd8;
    return CNT_W'(len - 32'sd1);
  endfunction

  // The holding register is free whenever it is empty, except in PRBS mode.
  assign tx.tx_ready = ~hold_vld_q & ~prbs_on;
  assign accept      = tx.tx_valid & tx.tx_ready;

  // Next-state logic: bit timer, preamble/payload sequencing, handshake, step latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    shift_d    = shift_q;
    pend_d     = pend_q;
    step_d     = step_q;
    sig_d      = sig_q;
    tick_d     = 1'b0;
    und_d      = 1'b0;
    bit_start  = 1'b0;
`ifdef PRBS_GEN_EN
    lfsr_d     = lfsr_q;
`endif

    if (state_q == S_IDLE) begin
      sig_d = 1'b0;
      if (enable) begin
        // Timer at zero makes the first bit start on the following edge.
        state_d = S_PRE;
        cnt_d   = '0;
        bcnt_d  = '0;
`ifdef PRBS_GEN_EN
        lfsr_d  = 7'h7F;
`endif
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (!enable) begin
      // Bit boundary with enable low: drop any partial byte, keep the holding register.
      state_d = S_IDLE;
      sig_d   = 1'b0;
      bcnt_d  = '0;
    end else begin
      bit_start = 1'b1;
      tick_d    = 1'b1;
      cnt_d     = bit_len_m1(pend_q, step_q);
      if (state_q == S_PRE && bcnt_q < BC_W'(PRE_BITS)) begin
        sig_d  = ~bcnt_q[0];
        bcnt_d = bcnt_q + BC_W'(1);
      end else begin
        state_d = S_PAY;
`ifdef PRBS_GEN_EN
        if (prbs_on) begin
          sig_d  = lfsr_q[6];
          lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end else
`endif
        if (state_q == S_PRE || bcnt_q == '0) begin
          if (hold_vld_q) begin
            sig_d      = hold_q[7];
            shift_d    = {hold_q[6:0], 1'b0};
            hold_vld_d = 1'b0;
          end else begin
            sig_d   = FILL[7];
            shift_d = {FILL[6:0], 1'b0};
            und_d   = 1'b1;
          end
        end else begin
          sig_d   = shift_q[7];
          shift_d = {shift_q[6:0], 1'b0};
        end
        if (state_q == S_PRE) bcnt_d = BC_W'(1);
        else                  bcnt_d = (bcnt_q == BC_W'(7)) ? '0 : bcnt_q + BC_W'(1);
      end
    end

    // A strobe coinciding with a bit start survives to the following bit.
    if (step_stb) begin
      step_d = phase_step;
      pend_d = 1'b1;
    end else if (bit_start) begin
      pend_d = 1'b0;
    end

    if (accept) begin
      hold_d     = tx.tx_data;
      hold_vld_d = 1'b1;
    end
  end

  // Control state and outputs, cleared by reset.
  always_ff @(posedge CLK_100MHz) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      hold_vld_q <= 1'b0;
      pend_q     <= 1'b0;
      sig_q      <= 1'b0;
      tick_q     <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      hold_vld_q <= hold_vld_d;
      pend_q     <= pend_d;
      sig_q      <= sig_d;
      tick_q     <= tick_d;
      und_q      <= und_d;
    end
  end

  // Data registers; their contents are qualified by the control flags above.
  always_ff @(posedge CLK_100MHz) begin
    hold_q  <= hold_d;
    shift_q <= shift_d;
    step_q  <= step_d;
`ifdef PRBS_GEN_EN
    lfsr_q  <= lfsr_d;
`endif
  end

  assign signal   = sig_q;
  assign bit_tick = tick_q;
  assign underrun = und_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_dpll_test_tx.sv
// Self-checking bench for dpll_test_tx: directed spec scenarios plus a
// randomized phase, all compared against a timestamp-based reference model.
module tb_dpll_test_tx;
  localparam int CPB = 16;
  localparam int SU  = 2;
  localparam int PB  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              step_stb;
  logic signed [7:0] phase_step;
  logic              prbs_mode;
  logic              signal, bit_tick, underrun, busy;

  dpll_test_tx_if txif();

  dpll_test_tx #(.CLK_PER_BIT(CPB), .STEP_UNIT(SU), .PRE_BITS(PB)) dut (
    .CLK_100MHz (clk),
    .reset      (reset),
    .enable     (enable),
    .tx         (txif),
    .phase_step (phase_step),
    .step_stb   (step_stb),
`ifdef PRBS_GEN_EN
    .prbs_mode  (prbs_mode),
`endif
    .signal     (signal),
    .bit_tick   (bit_tick),
    .underrun   (underrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: absolute next-bit-start time, bit index since enable,
  // and a one-entry byte buffer.
  bit                m_active = 0;
  int                m_next   = 0;
  int                m_bitno  = 0;
  bit                m_hold   = 0;
  logic [7:0]        m_hold_data = 8'h00;
  logic [7:0]        m_cur    = 8'h00;
  bit                m_pend   = 0;
  logic signed [7:0] m_step   = 8'sd0;
  logic [6:0]        m_lfsr   = 7'h7F;
  bit                e_sig = 0, e_tick = 0, e_und = 0;

  task automatic model_edge();
    int len, pos;
    bit start, rdy;
    cyc++;
    rdy    = !m_hold && !prbs_mode;
    start  = 0;
    e_tick = 0;
    e_und  = 0;
    if (reset) begin
      m_active = 0;
      m_hold   = 0;
      m_pend   = 0;
      e_sig    = 0;
      return;
    end
    if (!m_active) begin
      e_sig = 0;
      if (enable) begin
        m_active = 1;
        m_next   = cyc + 1;
        m_bitno  = 0;
        m_lfsr   = 7'h7F;
      end
    end else if (cyc == m_next) begin
      if (!enable) begin
        m_active = 0;
        e_sig    = 0;
      end else begin
        start  = 1;
        e_tick = 1;
        if (m_bitno < PB) begin
          e_sig = (m_bitno % 2 == 0);
        end else if (prbs_mode) begin
          e_sig  = m_lfsr[6];
          m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
        end else begin
          pos = (m_bitno - PB) % 8;
          if (pos == 0) begin
            if (m_hold) begin
              m_cur  = m_hold_data;
              m_hold = 0;
            end else begin
              m_cur = 8'h55;
              e_und = 1;
            end
          end
          e_sig = m_cur[7 - pos];
        end
        m_bitno++;
        len = CPB + (m_pend ? int'(m_step) * SU : 0);
        if (len < 8) len = 8;
        m_next = cyc + len;
      end
    end
    if (step_stb) begin
      m_step = phase_step;
      m_pend = 1;
    end else if (start) begin
      m_pend = 0;
    end
    if (txif.tx_valid && rdy) begin
      m_hold      = 1;
      m_hold_data = txif.tx_data;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  // Output monitor on the falling edge: compare against the model and log bits.
  bit          chk_on    = 0;
  int          tick_cnt  = 0;
  int          und_cnt   = 0;
  int          last_tick = 0;
  int          prev_tick = 0;
  logic [31:0] obs_bits  = '0;
  logic        tick_log[$];

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check_eq("signal",   signal,        e_sig);
        check_eq("bit_tick", bit_tick,      e_tick);
        check_eq("underrun", underrun,      e_und);
        check_eq("busy",     busy,          m_active);
        check_eq("tx_ready", txif.tx_ready, !m_hold && !prbs_mode);
      end
      if (bit_tick === 1'b1) begin
        tick_cnt++;
        prev_tick = last_tick;
        last_tick = cyc;
        obs_bits  = {obs_bits[30:0], signal};
        tick_log.push_back(signal);
        if (underrun === 1'b1) und_cnt++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_tick_abs(input int target);
    int guard;
    guard = 0;
    while (tick_cnt < target && guard < 20000) begin
      step();
      guard++;
    end
    if (tick_cnt < target) check_eq("tick_timeout", tick_cnt, target);
  endtask

  task automatic wait_ticks(input int n);
    wait_tick_abs(tick_cnt + n);
  endtask

  // Present a byte and hold it until the holding register takes it.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    txif.tx_valid = 1'b1;
    txif.tx_data  = b;
    guard = 0;
    while (!txif.tx_ready && guard < 2000) begin
      step();
      guard++;
    end
    if (!txif.tx_ready) check_eq("accept_timeout", txif.tx_ready, 1);
    step();
  endtask

  task automatic measure_step(input string tag, input logic signed [7:0] s, input int exp_len);
    wait_ticks(1);
    step();
    step();
    phase_step = s;
    step_stb   = 1'b1;
    step();
    step_stb   = 1'b0;
    wait_ticks(1);
    wait_ticks(1);
    check_eq(tag, last_tick - prev_tick, exp_len);
  endtask

  initial begin
    int base, u0, guard, mism;
    reset         = 1'b1;
    enable        = 1'b0;
    step_stb      = 1'b0;
    phase_step    = 8'sd0;
    prbs_mode     = 1'b0;
    txif.tx_valid = 1'b0;
    txif.tx_data  = 8'h00;

    step();
    chk_on = 1;
    step();
    check_eq("rst_signal", signal, 0);
    check_eq("rst_busy",   busy, 0);
    check_eq("rst_ready",  txif.tx_ready, 1);
    check_eq("rst_tick",   bit_tick, 0);
    reset = 1'b0;
    step();

    // Preamble followed by 8'hA5, 16-cycle bits.
    send_byte(8'hA5);
    txif.tx_valid = 1'b0;
    enable = 1'b1;
    wait_ticks(16);
    check_eq("t1_bits",   obs_bits[15:0], 16'hAAA5);
    check_eq("t1_period", last_tick - prev_tick, CPB);

    // No payload: fill bytes with one underrun each.
    u0 = und_cnt;
    wait_ticks(16);
    check_eq("t2_bits", obs_bits[15:0], 16'h5555);
    check_eq("t2_und",  und_cnt - u0, 2);

    // Back-to-back bytes with tx_valid held high.
    base = tick_cnt;
    u0   = und_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    txif.tx_valid = 1'b0;
    wait_tick_abs(base + 16);
    check_eq("t4_bits", obs_bits[15:0], 16'h00FF);
    check_eq("t4_und",  und_cnt - u0, 0);

    // Phase steps applied to the bit after the strobe.
    measure_step("step_p3",   8'sd3,    22);
    measure_step("step_m3",   -8'sd3,   10);
    measure_step("step_m128", -8'sd128, 8);

    // Disable mid-bit with a byte held; it survives into the next enable.
    wait_ticks(1);
    send_byte(8'h3C);
    txif.tx_valid = 1'b0;
    enable = 1'b0;
    guard = 0;
    while (busy && guard < 600) begin
      step();
      guard++;
    end
    check_eq("dis_busy",   busy, 0);
    check_eq("dis_signal", signal, 0);
    check_eq("dis_ready",  txif.tx_ready, 0);
    enable = 1'b1;
    wait_ticks(16);
    check_eq("reen_bits", obs_bits[15:0], 16'hAA3C);

    // Reset in cycle 5 of a payload bit with the holding register full.
    wait_ticks(1);
    send_byte(8'hC3);
    txif.tx_valid = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    check_eq("rst5_signal", signal, 0);
    check_eq("rst5_busy",   busy, 0);
    check_eq("rst5_ready",  txif.tx_ready, 1);
    reset = 1'b0;
    wait_ticks(8);
    check_eq("rst5_pre",  obs_bits[7:0], 8'hAA);
    wait_ticks(8);
    check_eq("rst5_fill", obs_bits[7:0], 8'h55);

    // Randomized traffic, steps, enable toggles and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      step_stb = ($urandom_range(0, 23) == 0);
      if (step_stb) phase_step = 8'($urandom);
      if (!txif.tx_valid) begin
        if ($urandom_range(0, 9) == 0) begin
          txif.tx_valid = 1'b1;
          txif.tx_data  = 8'($urandom);
        end
      end else if ($urandom_range(0, 2) == 0) begin
        txif.tx_valid = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      reset = ($urandom_range(0, 1499) == 0);
      step();
    end
    step_stb      = 1'b0;
    reset         = 1'b0;
    txif.tx_valid = 1'b0;

`ifdef PRBS_GEN_EN
    // PRBS-7 payload: first byte 11111110, period 127 bits.
    enable = 1'b0;
    reset  = 1'b1;
    step();
    reset     = 1'b0;
    prbs_mode = 1'b1;
    enable    = 1'b1;
    base = tick_cnt;
    wait_ticks(16);
    check_eq("prbs_first8", obs_bits[7:0], 8'hFE);
    check_eq("prbs_ready",  txif.tx_ready, 0);
    wait_ticks(254);
    mism = 0;
    for (int i = 0; i < 127; i++)
      if (tick_log[base + 8 + i] !== tick_log[base + 8 + i + 127]) mism++;
    check_eq("prbs_period", mism, 0);
    prbs_mode = 1'b0;
`endif

    enable = 1'b0;
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
